// File: rtl/weight_load_scheduler.sv
// -----------------------------------------------------------------------------
// weight_load_scheduler
//
// Sequences one convolution layer's weight loading for the data-transmission
// block: it fires a one-cycle init pulse, waits for the initial feature-map and
// weight RAM loads to complete (that initial load is group 0), then for every
// remaining kernel group it waits for the conv engine to consume the current
// group, issues a weight-RAM update request with per-lane write addresses, and
// runs the request/acknowledge handshake with the transmission block.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle layer request, ignored while busy
//   num_groups, base_addr    layer parameters, captured on an accepted start
//   init_fm_ram_ready        feature-map RAM initial load finished
//   init_weight_ram_ready    weight RAM initial load finished
//   weight_data_done         transmission block has the requested weights
//   group_consumed           one-cycle pulse, conv engine finished a group
//   init                     one-cycle init pulse to the transmission block
//   update_weight_ram        weight-RAM update request
//   update_weight_ram_addr   PARA_KERNEL lanes of write address, all equal
//   group_idx                index of the group currently loaded
//   busy                     layer in progress
//   layer_done               one-cycle pulse at the end of the layer
// -----------------------------------------------------------------------------
module weight_load_scheduler #(
    parameter int PARA_KERNEL             = 8,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 10,
    parameter int GROUP_W                 = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [GROUP_W-1:0]                             num_groups,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0]             base_addr,
    input  logic                                           init_fm_ram_ready,
    input  logic                                           init_weight_ram_ready,
    input  logic                                           weight_data_done,
    input  logic                                           group_consumed,
    output logic                                           init,
    output logic                                           update_weight_ram,
    output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] update_weight_ram_addr,
    output logic [GROUP_W-1:0]                             group_idx,
    output logic                                           busy,
    output logic                                           layer_done
);

    localparam int AW    = WEIGHT_WRITE_ADDR_WIDTH;
    // Sum wide enough for either operand; the result is truncated to AW bits.
    localparam int SUM_W = (AW > GROUP_W) ? AW : GROUP_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_WAIT_USE = 3'd3,
        ST_REQ      = 3'd4,
        ST_GAP      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t               state_r;
    logic [GROUP_W-1:0]   num_groups_r;
    logic [AW-1:0]        base_addr_r;
    logic [GROUP_W-1:0]   group_idx_r;
    logic [AW-1:0]        lane_addr_r;
    logic                 init_r;
    logic                 update_r;
    logic                 busy_r;
    logic                 layer_done_r;

    logic [GROUP_W-1:0]   next_idx_s;
    logic                 last_group_s;
    logic [AW-1:0]        next_lane_s;

    // Lane write address for a group: base plus index, wrapping modulo 2^AW.
    function automatic logic [AW-1:0] lane_addr_f(
        input logic [AW-1:0]      base,
        input logic [GROUP_W-1:0] idx
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(idx);
        return sum[AW-1:0];
    endfunction

    // Next-group index, last-group detect and the address of the next group.
    always_comb begin
        next_idx_s   = group_idx_r + GROUP_W'(1);
        last_group_s = (group_idx_r == (num_groups_r - GROUP_W'(1)));
        next_lane_s  = lane_addr_f(base_addr_r, next_idx_s);
    end

    // Layer sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            num_groups_r <= '0;
            base_addr_r  <= '0;
            group_idx_r  <= '0;
            lane_addr_r  <= '0;
            init_r       <= 1'b0;
            update_r     <= 1'b0;
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_groups_r <= num_groups;
                        base_addr_r  <= base_addr;
                        group_idx_r  <= '0;
                        lane_addr_r  <= base_addr;
                        busy_r       <= 1'b1;
                        if (num_groups == GROUP_W'(0)) begin
                            // Empty layer: skip loading, report completion.
                            layer_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            init_r  <= 1'b1;
                            state_r <= ST_INIT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end

                ST_INIT: begin
                    init_r  <= 1'b0;
                    state_r <= ST_WAIT_RDY;
                end

                ST_WAIT_RDY: begin
                    // Both flags must be seen together; the initial load is group 0.
                    if (init_fm_ram_ready && init_weight_ram_ready) begin
                        state_r <= ST_WAIT_USE;
                    end else begin
                        state_r <= ST_WAIT_RDY;
                    end
                end

                ST_WAIT_USE: begin
                    if (group_consumed) begin
                        if (last_group_s) begin
                            layer_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            group_idx_r <= next_idx_s;
                            lane_addr_r <= next_lane_s;
                            update_r    <= 1'b1;
                            state_r     <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_WAIT_USE;
                    end
                end

                ST_REQ: begin
                    // A done flag still high from before counts as the acknowledge.
                    if (weight_data_done) begin
                        update_r <= 1'b0;
                        state_r  <= ST_GAP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end

                ST_GAP: begin
                    // Wait for the transmission block to clear its done flag so
                    // the next request cannot be acknowledged by a stale level.
                    if (!weight_data_done) begin
                        state_r <= ST_WAIT_USE;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end

                ST_DONE: begin
                    layer_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end

                default: begin
                    init_r       <= 1'b0;
                    update_r     <= 1'b0;
                    busy_r       <= 1'b0;
                    layer_done_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign init                   = init_r;
    assign update_weight_ram      = update_r;
    assign update_weight_ram_addr = {PARA_KERNEL{lane_addr_r}};
    assign group_idx              = group_idx_r;
    assign busy                   = busy_r;
    assign layer_done             = layer_done_r;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// -----------------------------------------------------------------------------
// tb_weight_load_scheduler
//
// Directed bench for weight_load_scheduler. Inputs change 1 time unit after
// the rising edge and outputs are checked at the same point. A small
// transmission-block model raises weight_data_done two cycles after a request
// and clears it once the request drops; a negedge monitor logs request
// addresses and pulse counts.
// -----------------------------------------------------------------------------
module tb_weight_load_scheduler;

    localparam int PK = 8;
    localparam int W  = 10;
    localparam int GW = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [GW-1:0]   num_groups;
    logic [W-1:0]    base_addr;
    logic            init_fm_ram_ready;
    logic            init_weight_ram_ready;
    logic            weight_data_done;
    logic            group_consumed;
    logic            init;
    logic            update_weight_ram;
    logic [W*PK-1:0] update_weight_ram_addr;
    logic [GW-1:0]   group_idx;
    logic            busy;
    logic            layer_done;

    // Transmission-block model and its manual override.
    logic            model_en;
    logic            manual_done;
    logic            model_done_r;
    logic [3:0]      model_cnt_r;

    // Monitor state.
    logic            prev_update_r;
    int              upd_rises;
    int              init_cycles;
    int              done_cycles;
    int              overlap_cycles;
    logic [W-1:0]    addr_q[$];

    int              tests_run;
    int              tests_failed;

    weight_load_scheduler #(
        .PARA_KERNEL(PK),
        .WEIGHT_WRITE_ADDR_WIDTH(W),
        .GROUP_W(GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_groups(num_groups),
        .base_addr(base_addr),
        .init_fm_ram_ready(init_fm_ram_ready),
        .init_weight_ram_ready(init_weight_ram_ready),
        .weight_data_done(weight_data_done),
        .group_consumed(group_consumed),
        .init(init),
        .update_weight_ram(update_weight_ram),
        .update_weight_ram_addr(update_weight_ram_addr),
        .group_idx(group_idx),
        .busy(busy),
        .layer_done(layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign weight_data_done = model_en ? model_done_r : manual_done;

    // Transmission model: done rises two cycles after a request, falls after it drops.
    always @(posedge clk) begin
        if (!update_weight_ram) begin
            model_cnt_r  <= 4'd0;
            model_done_r <= 1'b0;
        end else begin
            model_cnt_r <= model_cnt_r + 4'd1;
            if (model_cnt_r == 4'd1) begin
                model_done_r <= 1'b1;
            end
        end
    end

    // Monitor: log request addresses (lane 0) and count pulses.
    always @(negedge clk) begin
        prev_update_r <= update_weight_ram;
        if (update_weight_ram && !prev_update_r) begin
            upd_rises <= upd_rises + 1;
            addr_q.push_back(update_weight_ram_addr[W-1:0]);
        end
        if (init)                init_cycles    <= init_cycles + 1;
        if (layer_done)          done_cycles    <= done_cycles + 1;
        if (init && layer_done)  overlap_cycles <= overlap_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W*PK-1:0] lanes(input logic [W-1:0] a);
        return {PK{a}};
    endfunction

    // Accept a layer; the caller decides when ready flags rise.
    task automatic start_layer(input logic [GW-1:0] ng, input logic [W-1:0] ba);
        num_groups = ng;
        base_addr  = ba;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // One model-acknowledged group; optional noise on start/consumed while busy.
    task automatic do_group(input string tag, input int exp_idx, input logic [W-1:0] exp_lane,
                            input bit noise);
        int cnt;
        group_consumed = 1'b1;
        tick();
        group_consumed = 1'b0;
        check_val({tag, "_req"},  {127'd0, update_weight_ram}, 128'd1);
        check_val({tag, "_idx"},  128'(group_idx), 128'(exp_idx));
        check_val({tag, "_addr"}, 128'(update_weight_ram_addr), 128'(lanes(exp_lane)));
        cnt = 0;
        while (update_weight_ram && cnt < 20) begin
            group_consumed = noise;
            start          = noise;
            tick();
            cnt = cnt + 1;
        end
        // One more cycle of noise lands in GAP.
        group_consumed = noise;
        start          = noise;
        tick();
        group_consumed = 1'b0;
        start          = 1'b0;
        check_val({tag, "_reqlen"}, 128'(cnt), 128'd3);
        check_val({tag, "_idxhold"}, 128'(group_idx), 128'(exp_idx));
        tick();
        tick();
    endtask

    // Final consumed pulse ends the layer.
    task automatic finish_layer(input string tag);
        group_consumed = 1'b1;
        tick();
        group_consumed = 1'b0;
        check_val({tag, "_done"},      {127'd0, layer_done}, 128'd1);
        check_val({tag, "_done_noreq"}, {127'd0, update_weight_ram}, 128'd0);
        tick();
        check_val({tag, "_done_low"}, {127'd0, layer_done}, 128'd0);
        check_val({tag, "_busy_low"}, {127'd0, busy}, 128'd0);
    endtask

    initial begin
        int base_rises;
        int base_inits;
        int base_dones;
        logic [W-1:0] a0;
        logic [W-1:0] a1;

        tests_run = 0;
        tests_failed = 0;
        upd_rises = 0;
        init_cycles = 0;
        done_cycles = 0;
        overlap_cycles = 0;
        prev_update_r = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        num_groups = '0;
        base_addr = '0;
        init_fm_ram_ready = 1'b0;
        init_weight_ram_ready = 1'b0;
        group_consumed = 1'b0;
        model_en = 1'b0;
        manual_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_init",   {127'd0, init}, 128'd0);
        check_val("rst_update", {127'd0, update_weight_ram}, 128'd0);
        check_val("rst_busy",   {127'd0, busy}, 128'd0);
        check_val("rst_addr",   128'(update_weight_ram_addr), 128'd0);
        tick();

        // Test 1: stale-ack pulse, then reset in the middle of a request.
        init_fm_ram_ready = 1'b1;
        init_weight_ram_ready = 1'b1;
        start_layer(8'd4, 10'h100);
        tick();
        tick();
        manual_done = 1'b1;
        group_consumed = 1'b1;
        tick();
        group_consumed = 1'b0;
        check_val("t1_stale_req",  {127'd0, update_weight_ram}, 128'd1);
        tick();
        check_val("t1_stale_drop", {127'd0, update_weight_ram}, 128'd0);
        manual_done = 1'b0;
        tick();
        group_consumed = 1'b1;
        tick();
        group_consumed = 1'b0;
        tick();
        check_val("t1_idx2",  128'(group_idx), 128'd2);
        check_val("t1_req",   {127'd0, update_weight_ram}, 128'd1);
        check_val("t1_addr",  128'(update_weight_ram_addr), 128'(lanes(10'h102)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t1_rst_update", {127'd0, update_weight_ram}, 128'd0);
        check_val("t1_rst_idx",    128'(group_idx), 128'd0);
        check_val("t1_rst_busy",   {127'd0, busy}, 128'd0);
        check_val("t1_rst_addr",   128'(update_weight_ram_addr), 128'd0);
        tick();

        // Test 2: three groups, ready flags at cycle 5, model acks.
        model_en = 1'b1;
        init_fm_ram_ready = 1'b0;
        init_weight_ram_ready = 1'b0;
        addr_q.delete();
        base_rises = upd_rises;
        start_layer(8'd3, 10'h010);
        check_val("t2_init_c1", {127'd0, init}, 128'd1);
        check_val("t2_busy_c1", {127'd0, busy}, 128'd1);
        check_val("t2_idx_c1",  128'(group_idx), 128'd0);
        tick();
        check_val("t2_init_c2", {127'd0, init}, 128'd0);
        tick();
        tick();
        init_fm_ram_ready = 1'b1;
        init_weight_ram_ready = 1'b1;
        tick();
        do_group("t2_g1", 1, 10'h011, 1'b0);
        do_group("t2_g2", 2, 10'h012, 1'b0);
        finish_layer("t2");
        check_val("t2_nreq", 128'(upd_rises - base_rises), 128'd2);
        a0 = (addr_q.size() > 0) ? addr_q[0] : '1;
        a1 = (addr_q.size() > 1) ? addr_q[1] : '1;
        check_val("t2_log0", 128'(a0), 128'h011);
        check_val("t2_log1", 128'(a1), 128'h012);

        // Test 3: empty layer.
        base_rises = upd_rises;
        base_inits = init_cycles;
        start_layer(8'd0, 10'h055);
        check_val("t3_done", {127'd0, layer_done}, 128'd1);
        check_val("t3_init", {127'd0, init}, 128'd0);
        tick();
        check_val("t3_done_low", {127'd0, layer_done}, 128'd0);
        check_val("t3_busy_low", {127'd0, busy}, 128'd0);
        check_val("t3_nreq",  128'(upd_rises - base_rises), 128'd0);
        check_val("t3_ninit", 128'(init_cycles - base_inits), 128'd0);

        // Test 4: address wrap from 0x3FF.
        start_layer(8'd3, 10'h3FF);
        tick();
        tick();
        do_group("t4_g1", 1, 10'h000, 1'b0);
        do_group("t4_g2", 2, 10'h001, 1'b0);
        finish_layer("t4");

        // Test 5: start and consumed noise during REQ/GAP are ignored.
        addr_q.delete();
        base_rises = upd_rises;
        base_dones = done_cycles;
        start_layer(8'd3, 10'h010);
        tick();
        tick();
        do_group("t5_g1", 1, 10'h011, 1'b1);
        do_group("t5_g2", 2, 10'h012, 1'b1);
        finish_layer("t5");
        check_val("t5_nreq", 128'(upd_rises - base_rises), 128'd2);
        check_val("t5_ndone", 128'(done_cycles - base_dones), 128'd1);
        a0 = (addr_q.size() > 0) ? addr_q[0] : '1;
        a1 = (addr_q.size() > 1) ? addr_q[1] : '1;
        check_val("t5_log0", 128'(a0), 128'h011);
        check_val("t5_log1", 128'(a1), 128'h012);

        // Test 6: single group, ready flags already high.
        base_rises = upd_rises;
        start_layer(8'd1, 10'h200);
        check_val("t6_init", {127'd0, init}, 128'd1);
        tick();
        tick();
        finish_layer("t6");
        check_val("t6_nreq", 128'(upd_rises - base_rises), 128'd0);

        tick();
        check_val("init_done_overlap", 128'(overlap_cycles), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
